// File: rtl/uds_pkg.sv
// rtl/uds_pkg.sv - shared constants, mode encodings and issue-FSM states for the UDS tile path
package uds_pkg;
    localparam int DW        = 16;
    localparam int ROW_ITEMS = 8;

    localparam logic [1:0] FM_MAX = 2'b00;
    localparam logic [1:0] FM_AVG = 2'b01;
    localparam logic [1:0] SF_2X2 = 2'd0;
    localparam logic [1:0] SF_3X3 = 2'd1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_HOLD,
        ST_DRAIN
    } issue_state_e;

    // Upsampling modes are flagged by the top bit of function_mode.
    function automatic logic fm_is_up(input logic [1:0] fm);
        return fm[1];
    endfunction
endpackage

// File: rtl/uds_tile_buf.sv
// rtl/uds_tile_buf.sv - two-bank tile buffer with per-bank config tags and full flags
module uds_tile_buf
    import uds_pkg::*;
#(
    parameter int A  = 64,
    parameter int DW = 16,
    parameter int CW = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic                     wr_bank,
    input  logic [CW-1:0]            wr_row,
    input  logic [ROW_ITEMS*DW-1:0]  wr_data,
    input  logic                     tag_en,
    input  logic [3:0]               tag_in,
    input  logic                     set_full,
    input  logic                     clr_en,
    input  logic                     clr_bank,
    input  logic                     rd_bank,
    output logic [A*DW-1:0]          rd_data,
    output logic [3:0]               rd_tag,
    output logic [1:0]               full
);
    localparam int RW = ROW_ITEMS * DW;

    logic [A*DW-1:0] bank_q [2];
    logic [A*DW-1:0] bank_d [2];
    logic [3:0]      tag_q  [2];
    logic [3:0]      tag_d  [2];
    logic [1:0]      full_q, full_d;

    always_comb begin
        bank_d = bank_q;
        tag_d  = tag_q;
        full_d = full_q;
        if (wr_en) begin
            bank_d[wr_bank][wr_row*RW +: RW] = wr_data;
        end
        if (tag_en) begin
            tag_d[wr_bank] = tag_in;
        end
        if (set_full) begin
            full_d[wr_bank] = 1'b1;
        end
        if (clr_en) begin
            full_d[clr_bank] = 1'b0;
        end
    end

    // Clearing the full flags is enough to discard both banks on reset.
    always_ff @(posedge clk) begin
        bank_q <= bank_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            full_q <= 2'b00;
            tag_q  <= '{default: 4'h0};
        end else begin
            full_q <= full_d;
            tag_q  <= tag_d;
        end
    end

    assign rd_data = bank_q[rd_bank];
    assign rd_tag  = tag_q[rd_bank];
    assign full    = full_q;
endmodule

// File: rtl/uds_tile_feeder.sv
// rtl/uds_tile_feeder.sv - packs 8-item rows into A-item tiles and issues them to the UDS engine
module uds_tile_feeder
    import uds_pkg::*;
#(
    parameter int A  = 64,
    parameter int DW = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [ROW_ITEMS*DW-1:0]  in_data,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [1:0]               cfg_scale_factor,
    input  logic [1:0]               cfg_function_mode,
    output logic [A*DW-1:0]          idata,
    output logic                     idata_valid,
    output logic                     active,
    output logic [1:0]               scale_factor,
    output logic [1:0]               function_mode,
    output logic [15:0]              tiles_issued
);
    localparam int BEATS = A / ROW_ITEMS;
    localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CW-1:0] LAST_BEAT = CW'(BEATS - 1);

    issue_state_e    state_q, state_d;
    logic [CW-1:0]   beat_q, beat_d;
    logic            wr_ptr_q, wr_ptr_d;
    logic            rd_ptr_q, rd_ptr_d;
    logic [A*DW-1:0] idata_q, idata_d;
    logic            idata_valid_q, idata_valid_d;
    logic            active_q, active_d;
    logic [1:0]      scale_factor_q, scale_factor_d;
    logic [1:0]      function_mode_q, function_mode_d;
    logic [15:0]     tiles_q, tiles_d;

    logic [1:0]      full;
    logic [A*DW-1:0] rd_data;
    logic [3:0]      rd_tag;
    logic            accept, last_beat, load, load_bank, drain;

    assign in_ready  = ~(full[0] & full[1]);
    assign accept    = in_valid & in_ready;
    assign last_beat = accept && (beat_q == LAST_BEAT);

    always_comb begin
        beat_d   = beat_q;
        wr_ptr_d = wr_ptr_q;
        if (accept) begin
            if (beat_q == LAST_BEAT) begin
                beat_d   = '0;
                wr_ptr_d = ~wr_ptr_q;
            end else begin
                beat_d = beat_q + 1'b1;
            end
        end
    end

    // DRAIN may chain straight into the next ISSUE when the other bank is
    // already full, which gives back-to-back tiles a 3-cycle spacing.
    always_comb begin
        state_d         = state_q;
        rd_ptr_d        = rd_ptr_q;
        load            = 1'b0;
        load_bank       = rd_ptr_q;
        drain           = 1'b0;
        idata_valid_d   = 1'b0;
        active_d        = 1'b0;
        idata_d         = idata_q;
        scale_factor_d  = scale_factor_q;
        function_mode_d = function_mode_q;
        tiles_d         = tiles_q;
        case (state_q)
            ST_IDLE: begin
                if (full[rd_ptr_q]) begin
                    load    = 1'b1;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                tiles_d  = tiles_q + 16'd1;
                active_d = 1'b1;
                state_d  = ST_HOLD;
            end
            ST_HOLD: begin
                state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                drain     = 1'b1;
                rd_ptr_d  = ~rd_ptr_q;
                load_bank = ~rd_ptr_q;
                if (full[~rd_ptr_q]) begin
                    load    = 1'b1;
                    state_d = ST_ISSUE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (load) begin
            idata_d                           = rd_data;
            {scale_factor_d, function_mode_d} = rd_tag;
            idata_valid_d                     = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            state_q         <= ST_IDLE;
            beat_q          <= '0;
            wr_ptr_q        <= 1'b0;
            rd_ptr_q        <= 1'b0;
            idata_q         <= '0;
            idata_valid_q   <= 1'b0;
            active_q        <= 1'b0;
            scale_factor_q  <= 2'd0;
            function_mode_q <= 2'd0;
            tiles_q         <= 16'd0;
        end else begin
            state_q         <= state_d;
            beat_q          <= beat_d;
            wr_ptr_q        <= wr_ptr_d;
            rd_ptr_q        <= rd_ptr_d;
            idata_q         <= idata_d;
            idata_valid_q   <= idata_valid_d;
            active_q        <= active_d;
            scale_factor_q  <= scale_factor_d;
            function_mode_q <= function_mode_d;
            tiles_q         <= tiles_d;
        end
    end

    uds_tile_buf #(
        .A  (A),
        .DW (DW),
        .CW (CW)
    ) u_buf (
        .clk      (clk),
        .rst      (rst_n),
        .wr_en    (accept),
        .wr_bank  (wr_ptr_q),
        .wr_row   (beat_q),
        .wr_data  (in_data),
        .tag_en   (accept && (beat_q == '0)),
        .tag_in   ({cfg_scale_factor, cfg_function_mode}),
        .set_full (last_beat),
        .clr_en   (drain),
        .clr_bank (rd_ptr_q),
        .rd_bank  (load_bank),
        .rd_data  (rd_data),
        .rd_tag   (rd_tag),
        .full     (full)
    );

    assign idata         = idata_q;
    assign idata_valid   = idata_valid_q;
    assign active        = active_q;
    assign scale_factor  = scale_factor_q;
    assign function_mode = function_mode_q;
    assign tiles_issued  = tiles_q;
endmodule

// File: doc/uds_tile_feeder.md
# uds_tile_feeder

Upstream stage of the up/down-sampling engine. Accepts one 8-item row (8 × 16-bit) per beat over a valid/ready stream and packs A/8 beats into a full A-item tile in a two-bank buffer. It issues each tile to the UDS engine with the idata_valid / active pulse sequence the engine needs for its shift / compute / shift phases, and holds the tile's mode fields stable for the whole window.

## Interface
- A, 64: items per tile; A/8 beats per tile (64 → 8 beats, 32 → 4 beats).
- DW, 16: bits per item.
- clk  in  1  clock; all state on rising edge.
- rst_n  in  1  synchronous reset, active-high (name kept for codebase consistency); one clock, reset is synchronous and active-high.
- in_data  in  8*DW  one row, item j at [j*DW +: DW].
- in_valid  in  1  row present.
- in_ready  out  1  row accepted when in_valid && in_ready.
- cfg_scale_factor  in  2  sampled with the first beat of a tile.
- cfg_function_mode  in  2  sampled with the first beat of a tile.
- idata  out  A*DW  tile to UDS; beat k at [k*8*DW +: 8*DW].
- idata_valid  out  1  one-cycle tile-issue strobe.
- active  out  1  UDS compute-phase flag.
- scale_factor  out  2  mode of the tile currently issued.
- function_mode  out  2  mode of the tile currently issued.
- tiles_issued  out  16  issue count; wraps 0xFFFF → 0.

## Operation
- Fill side: beat counter 0..A/8-1 and write-bank pointer. Beat k goes to row k of the write bank. The config is latched into that bank's tag when k==0. When the last beat is accepted, the bank is marked full, the pointer toggles and the counter returns to 0.
- in_ready = (full-bank count < 2). This comes combinationally from registers only, with no path from in_valid.
- Issue FSM:
  - IDLE: if a bank is full, go to ISSUE.
  - ISSUE: idata_valid=1, active=0 → HOLD.
  - HOLD: idata_valid=0, active=1 → DRAIN.
  - DRAIN: both 0. Free the read bank, toggle the read pointer → IDLE.
- IDLE goes to ISSUE again in the same cycle a bank becomes full. Minimum issue spacing is 3 cycles.
- idata, scale_factor and function_mode load from the read bank on entry to ISSUE. They hold until the next ISSUE and are never driven from the write bank.
- tiles_issued increments on each ISSUE cycle.
- Simultaneous events:
  - Last beat accepted in the same cycle DRAIN frees a bank: the count stays the same (+1 −1).
  - in_ready is computed before the free, so it is 0 for that cycle if the count was 2.
- Config changes mid-tile have no effect until the first beat of the next tile.
- Reset mid-operation discards any partial tile and both banks, and forces IDLE.

## Timing
- Reset values:
  - idata = 0, idata_valid = 0, active = 0, scale_factor = 0, function_mode = 0, tiles_issued = 0.
  - in_ready = 1 the cycle after reset deasserts.
  - Internal beat counter, pointers and count are all 0.
- All outputs except in_ready are registered.
- Latency: with the FSM in IDLE and the other bank empty, the last beat is accepted at edge t, then:
  - ISSUE (idata_valid=1) is visible after edge t+1;
  - active=1 after edge t+2;
  - both low after edge t+3.
- Steady state with in_valid held high:
  - A=64: 8 accept cycles per tile, issue every 8 cycles, no stall.
  - A=32: 4 accept cycles per tile against 3 issue cycles, so also no stall.
- Buffer full: both banks full means in_ready=0. It rises the cycle after DRAIN.

## Structure
- Shared package uds_pkg holds:
  - DW=16 and ROW_ITEMS=8.
  - Mode encodings: FM_UP = function_mode[1]==1; FM_MAX=2'b00, FM_AVG=2'b01; SF_2X2=2'd0, SF_3X3=2'd1.
  - The issue-FSM state enum.
- One sub-module, uds_tile_buf: two A*DW banks plus 4-bit config tags, with a write port (bank, row, data), read mux and full flags. The FSM and counters live in the top.

## Test plan
- Reset, then 8 beats with row k items all = k+1 and mode 2'b10: one idata_valid pulse, idata[k*128 +:16] = k+1, then active=1 for exactly one cycle, function_mode=2'b10, tiles_issued=1.
- 24 back-to-back beats with in_valid held high, A=64: in_ready is never 0; idata_valid pulses 8 cycles apart; tiles_issued=3.
- Hold the UDS side by holding the producer at a tile boundary: with 16 beats loaded, a third tile's first beat is stalled (in_ready=0) until DRAIN of tile 1; no data loss, and tile order is 1,2,3.
- cfg_function_mode changed from 2'b01 to 2'b00 at beat 4 of a tile: that tile issues with 2'b01, and the next tile issues with 2'b00.
- rst_n asserted after beat 5 of a tile: all outputs are 0; the 8 subsequent beats form a fresh tile with no residue.
- 65536 tiles issued: tiles_issued wraps to 0.
